// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
// master drives the requests; slave is the FIFO.
interface sync_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic [1:0]        wr_state;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  wr_ack, rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, wr_state, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output wr_ack, rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, wr_state, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy counter, threshold flags, sticky errors
// and an observational write-side state machine.
module sync_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input logic            clk,
  input logic            arst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FULL = 2'd1,
    ST_PUSH = 2'd2
  } wr_state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;
  wr_state_t         r_wr_state;

  logic w_full;
  logic w_empty;
  logic w_acc_w;
  logic w_acc_r;

  // Flags come from the registered count, so accepts see start-of-cycle state.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_acc_w = bus.wr_en & ~w_full;
  assign w_acc_r = bus.rd_en & ~w_empty;

  assign bus.wr_ack       = w_acc_w;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AFULL_C);
  assign bus.almost_empty = (r_count <= AEMPTY_C);
  assign bus.count        = r_count;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.wr_state     = r_wr_state;

  // Storage is not reset; a write landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (w_acc_w && !arst) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_acc_w) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_acc_r) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_acc_r;
      r_count    <= r_count + CNT_W'(w_acc_w) - CNT_W'(w_acc_r);

      // A new error event outranks a clear in the same cycle.
      if (bus.wr_en && w_full)       r_overflow  <= 1'b1;
      else if (bus.clr_err)          r_overflow  <= 1'b0;
      if (bus.rd_en && w_empty)      r_underflow <= 1'b1;
      else if (bus.clr_err)          r_underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wr_state <= ST_WAIT;
    end else begin
      case (r_wr_state)
        ST_WAIT, ST_FULL, ST_PUSH: begin
          if (w_full)          r_wr_state <= ST_FULL;
          else if (bus.wr_en)  r_wr_state <= ST_PUSH;
          else                 r_wr_state <= ST_WAIT;
        end
        default:               r_wr_state <= ST_WAIT;
      endcase
    end
  end
endmodule
